// File: rtl/pipe_reg_pkg.sv
// Shared definitions for pipeline-stage registers and future pipe FIFOs.
// Occupancy encodings for the skid-buffered stage.
package pipe_reg_pkg;

    localparam logic [1:0] PIPE_EMPTY = 2'd0;
    localparam logic [1:0] PIPE_BUSY  = 2'd1;
    localparam logic [1:0] PIPE_FULL  = 2'd2;

endpackage

// File: rtl/pipe_reg_if.sv
// Valid/ready payload channel between pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_reg_if #(
    parameter int width = 32
);

    logic             valid;
    logic             ready;
    logic [width-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/pipe_reg.sv
// Pipeline-stage register with valid/ready handshake and sync flush.
// SKID=1 adds a second entry so in_ready no longer depends on out_ready.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter int               width      = 32,
    parameter logic [width-1:0] flush_data = '0,
    parameter bit               SKID       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    pipe_reg_if.slave  in_if,
    pipe_reg_if.master out_if
);

    logic             in_ready;
    logic             in_fire;
    logic             out_valid;
    logic             out_fire;
    logic [width-1:0] out_data;

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = out_data;

    assign in_fire  = in_if.valid & in_ready;
    assign out_fire = out_valid & out_if.ready;

    generate
        if (SKID) begin : g_skid
            logic [1:0]       state_q, state_d;
            logic [width-1:0] main_q, main_d;
            logic [width-1:0] skid_q, skid_d;

            // Only registered state feeds in_ready, cutting the ready path.
            assign in_ready  = (state_q != PIPE_FULL) & !flush;
            assign out_valid = (state_q != PIPE_EMPTY);
            assign out_data  = main_q;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = PIPE_EMPTY;
                    main_d  = flush_data;
                    skid_d  = flush_data;
                end else begin
                    unique case (state_q)
                        PIPE_EMPTY: begin
                            if (in_fire) begin
                                state_d = PIPE_BUSY;
                                main_d  = in_if.data;
                            end
                        end
                        PIPE_BUSY: begin
                            if (in_fire && out_fire) begin
                                main_d = in_if.data;
                            end else if (in_fire) begin
                                state_d = PIPE_FULL;
                                skid_d  = in_if.data;
                            end else if (out_fire) begin
                                state_d = PIPE_EMPTY;
                            end
                        end
                        PIPE_FULL: begin
                            if (out_fire) begin
                                state_d = PIPE_BUSY;
                                main_d  = skid_q;
                            end
                        end
                        default: state_d = PIPE_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= PIPE_EMPTY;
                    main_q  <= flush_data;
                    skid_q  <= flush_data;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end else begin : g_bare
            logic             valid_q, valid_d;
            logic [width-1:0] main_q, main_d;

            assign in_ready  = (!valid_q | out_if.ready) & !flush;
            assign out_valid = valid_q;
            assign out_data  = main_q;

            always_comb begin
                valid_d = valid_q;
                main_d  = main_q;
                if (flush) begin
                    valid_d = 1'b0;
                    main_d  = flush_data;
                end else if (in_fire) begin
                    valid_d = 1'b1;
                    main_d  = in_if.data;
                end else if (out_fire) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_q <= 1'b0;
                    main_q  <= flush_data;
                end else begin
                    valid_q <= valid_d;
                    main_q  <= main_d;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: both modes side by side against a queue model.
// Directed scenarios followed by random handshake/flush traffic.
module tb_pipe_reg;

    localparam logic [31:0] FD = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_reg_if #(.width(32)) u0_in ();
    pipe_reg_if #(.width(32)) u0_out ();
    pipe_reg_if #(.width(32)) u1_in ();
    pipe_reg_if #(.width(32)) u1_out ();

    pipe_reg #(.width(32), .flush_data(FD), .SKID(1'b0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .in_if (u0_in),
        .out_if(u0_out)
    );

    pipe_reg #(.width(32), .flush_data(FD), .SKID(1'b1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .in_if (u1_in),
        .out_if(u1_out)
    );

    always #5 clk = ~clk;

    // Reference: a FIFO of depth 1 (SKID=0) or 2 (SKID=1).
    logic [31:0] mq [2][$];
    logic [31:0] hold [2];
    logic        p_hold [2];
    logic [31:0] p_data [2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            hold[k]   = FD;
            p_hold[k] = 1'b0;
            p_data[k] = FD;
        end
    endtask

    function automatic logic m_ready(int k, logic orr, logic fl);
        if (fl) return 1'b0;
        if (k == 0) return (mq[0].size() == 0) || orr;
        return mq[1].size() < 2;
    endfunction

    // Called at a negedge; drives, checks, advances model, ends at negedge.
    task automatic cycle(input logic iv, input logic [31:0] d,
                         input logic orr, input logic fl);
        logic        ev, er, ov, orv;
        logic [31:0] ed, od;
        u0_in.valid = iv;
        u1_in.valid = iv;
        u0_in.data  = d;
        u1_in.data  = d;
        u0_out.ready = orr;
        u1_out.ready = orr;
        flush = fl;
        #1;
        for (int k = 0; k < 2; k++) begin
            ev = mq[k].size() > 0;
            ed = ev ? mq[k][0] : hold[k];
            er = m_ready(k, orr, fl);
            ov  = (k == 0) ? u0_out.valid : u1_out.valid;
            od  = (k == 0) ? u0_out.data : u1_out.data;
            orv = (k == 0) ? u0_in.ready : u1_in.ready;
            check($sformatf("valid%0d", k), 32'(ov), 32'(ev));
            check($sformatf("ready%0d", k), 32'(orv), 32'(er));
            check($sformatf("data%0d", k), od, ed);
            if (p_hold[k]) begin
                check($sformatf("stable_v%0d", k), 32'(ov), 32'd1);
                check($sformatf("stable_d%0d", k), od, p_data[k]);
            end
            p_hold[k] = ev & !orr & !fl;
            p_data[k] = ed;
            if (fl) begin
                mq[k].delete();
                hold[k] = FD;
            end else begin
                if (ev && orr) hold[k] = mq[k].pop_front();
                if (iv && er) mq[k].push_back(d);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        u0_in.valid = 1'b0;
        u1_in.valid = 1'b0;
        u0_in.data  = '0;
        u1_in.data  = '0;
        u0_out.ready = 1'b0;
        u1_out.ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_v0", 32'(u0_out.valid), 32'd0);
        check("rst_v1", 32'(u1_out.valid), 32'd0);
        check("rst_d0", u0_out.data, FD);
        check("rst_d1", u1_out.data, FD);
        check("rst_r1", 32'(u1_in.ready), 32'd1);
        rst = 1'b1;

        // Streaming
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        check("stream_last1", u1_out.data, 32'd4);
        cycle(1'b0, 32'd0, 1'b1, 1'b0);

        // Back-pressure into FULL, then drain in order
        cycle(1'b1, 32'hA, 1'b0, 1'b0);
        cycle(1'b1, 32'hB, 1'b0, 1'b0);
        cycle(1'b1, 32'hC, 1'b0, 1'b0);
        check("bp_ready", 32'(u1_in.ready), 32'd0);
        check("bp_data", u1_out.data, 32'hA);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_drain_b", u1_out.data, 32'hB);
        cycle(1'b1, 32'hC, 1'b1, 1'b0);
        check("bp_drain_c", u1_out.data, 32'hC);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while FULL
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b1);
        check("fl_v1", 32'(u1_out.valid), 32'd0);
        check("fl_d1", u1_out.data, FD);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("fl_r1", 32'(u1_in.ready), 32'd1);

        // Async reset while BUSY
        cycle(1'b1, 32'h44, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("ar_v0", 32'(u0_out.valid), 32'd0);
        check("ar_v1", 32'(u1_out.valid), 32'd0);
        check("ar_d1", u1_out.data, FD);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle(1'b1, 32'h5, 1'b0, 1'b0);
        check("ar_five1", u1_out.data, 32'h5);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Idle hold with back-pressure
        cycle(1'b1, 32'h7, 1'b0, 1'b0);
        repeat (10) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        check("idle_d1", u1_out.data, 32'h7);

        // SKID=0 ready follows out_ready combinationally
        u0_out.ready = 1'b0;
        #1 check("comb_r0_lo", 32'(u0_in.ready), 32'd0);
        u0_out.ready = 1'b1;
        #1 check("comb_r0_hi", 32'(u0_in.ready), 32'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
